// File: rtl/spi_master_datapath.sv
// rtl/spi_master_datapath.sv - SPI mode 0 byte datapath: TX hold/shift register, MISO sampler, RX valid/ack
module spi_master_datapath #(
  parameter int DATA_WIDTH = 8,
  parameter bit MSB_FIRST  = 1'b1
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic [DATA_WIDTH-1:0] tx_data_i,
  input  logic                  tx_valid_i,
  output logic                  tx_ready_o,
  input  logic                  load_data_en_i,
  input  logic                  shift_enable_i,
  input  logic                  spi_clk_i,
  input  logic                  miso_i,
  output logic                  mosi_o,
  output logic [DATA_WIDTH-1:0] rx_data_o,
  output logic                  rx_valid_o,
  input  logic                  rx_ack_i,
  output logic                  rx_overrun_o,
  output logic                  busy_o
);

  localparam int CW = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

  logic [DATA_WIDTH-1:0] r_hold;
  logic                  r_hold_full;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [DATA_WIDTH-1:0] r_rx_shift;
  logic [CW-1:0]         r_bit_cnt;
  logic                  r_spi_clk_q;
  logic                  r_busy;
  logic [DATA_WIDTH-1:0] r_rx_data;
  logic                  r_rx_valid;
  logic                  r_rx_overrun;

  logic                  w_rise;
  logic                  w_sample;
  logic                  w_done;
  logic                  w_out_bit;
  logic [DATA_WIDTH-1:0] w_rx_next;
  logic [DATA_WIDTH-1:0] w_shift_next;
  logic [DATA_WIDTH-1:0] w_load_word;

  assign w_rise   = spi_clk_i & ~r_spi_clk_q;
  assign w_sample = w_rise & r_busy;
  assign w_done   = w_sample & (r_bit_cnt == LAST_BIT);

  always_comb begin
    w_rx_next    = '0;
    w_shift_next = '1;
    w_out_bit    = 1'b1;
    if (MSB_FIRST) begin
      w_rx_next    = {r_rx_shift[DATA_WIDTH-2:0], miso_i};
      w_shift_next = {r_shift[DATA_WIDTH-2:0], 1'b1};
      w_out_bit    = r_shift[DATA_WIDTH-1];
    end else begin
      w_rx_next    = {miso_i, r_rx_shift[DATA_WIDTH-1:1]};
      w_shift_next = {1'b1, r_shift[DATA_WIDTH-1:1]};
      w_out_bit    = r_shift[0];
    end
  end

  // Held word first, then same-cycle bypass, else an all-ones dummy word for read-only transfers
  always_comb begin
    w_load_word = '1;
    if (r_hold_full) begin
      w_load_word = r_hold;
    end else if (tx_valid_i) begin
      w_load_word = tx_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_hold      <= '0;
      r_hold_full <= 1'b0;
    end else if (load_data_en_i) begin
      r_hold_full <= 1'b0;
    end else if (tx_valid_i && !r_hold_full) begin
      r_hold      <= tx_data_i;
      r_hold_full <= 1'b1;
    end
  end

  // A load always wins, so a load coincident with completion restarts with busy held high
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_shift    <= '1;
      r_rx_shift <= '0;
      r_bit_cnt  <= '0;
      r_busy     <= 1'b0;
    end else if (load_data_en_i) begin
      r_shift    <= w_load_word;
      r_rx_shift <= '0;
      r_bit_cnt  <= '0;
      r_busy     <= 1'b1;
    end else begin
      if (shift_enable_i && r_busy) begin
        r_shift <= w_shift_next;
      end
      if (w_done) begin
        r_rx_shift <= '0;
        r_bit_cnt  <= '0;
        r_busy     <= 1'b0;
      end else if (w_sample) begin
        r_rx_shift <= w_rx_next;
        r_bit_cnt  <= r_bit_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_spi_clk_q  <= 1'b0;
      r_rx_data    <= '0;
      r_rx_valid   <= 1'b0;
      r_rx_overrun <= 1'b0;
    end else begin
      r_spi_clk_q <= spi_clk_i;
      if (w_done) begin
        r_rx_data    <= w_rx_next;
        r_rx_valid   <= 1'b1;
        r_rx_overrun <= r_rx_valid & ~rx_ack_i;
      end else if (rx_ack_i && r_rx_valid) begin
        r_rx_valid   <= 1'b0;
        r_rx_overrun <= 1'b0;
      end
    end
  end

  assign tx_ready_o   = ~r_hold_full;
  assign mosi_o       = r_busy ? w_out_bit : 1'b1;
  assign busy_o       = r_busy;
  assign rx_data_o    = r_rx_data;
  assign rx_valid_o   = r_rx_valid;
  assign rx_overrun_o = r_rx_overrun;

endmodule

// File: tb/tb_spi_master_datapath.sv
// tb/tb_spi_master_datapath.sv - scoreboard bench driving MSB-first and LSB-first datapaths in lockstep
module tb_spi_master_datapath;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rstn, tx_valid, load, shift_en, spi_clk, miso, rx_ack;
  logic [7:0] tx_data;

  logic       m_tx_ready, m_mosi, m_rx_valid, m_ovr, m_busy;
  logic [7:0] m_rx_data;
  logic       l_tx_ready, l_mosi, l_rx_valid, l_ovr, l_busy;
  logic [7:0] l_rx_data;

  spi_master_datapath #(.DATA_WIDTH(8), .MSB_FIRST(1'b1)) u_dut_msb (
    .clk_i(clk), .rstn_i(rstn), .tx_data_i(tx_data), .tx_valid_i(tx_valid),
    .tx_ready_o(m_tx_ready), .load_data_en_i(load), .shift_enable_i(shift_en),
    .spi_clk_i(spi_clk), .miso_i(miso), .mosi_o(m_mosi), .rx_data_o(m_rx_data),
    .rx_valid_o(m_rx_valid), .rx_ack_i(rx_ack), .rx_overrun_o(m_ovr), .busy_o(m_busy)
  );

  spi_master_datapath #(.DATA_WIDTH(8), .MSB_FIRST(1'b0)) u_dut_lsb (
    .clk_i(clk), .rstn_i(rstn), .tx_data_i(tx_data), .tx_valid_i(tx_valid),
    .tx_ready_o(l_tx_ready), .load_data_en_i(load), .shift_enable_i(shift_en),
    .spi_clk_i(spi_clk), .miso_i(miso), .mosi_o(l_mosi), .rx_data_o(l_rx_data),
    .rx_valid_o(l_rx_valid), .rx_ack_i(rx_ack), .rx_overrun_o(l_ovr), .busy_o(l_busy)
  );

  typedef struct {
    logic [7:0] data;
    logic       ovr;
  } rx_exp_t;

  int         n_chk = 0;
  int         n_fail = 0;
  rx_exp_t    rxq_m[$];
  rx_exp_t    rxq_l[$];
  logic       mq_m[$];
  logic       mq_l[$];
  bit         in_xfer = 1'b0;
  bit         mdl_pending = 1'b0;
  bit         mdl_hold_full = 1'b0;
  logic [7:0] mdl_hold = 8'h00;
  bit         pb_m = 1'b0;
  bit         pb_l = 1'b0;
  rx_exp_t    e_m, e_l;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] rev8(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[7-i];
    return r;
  endfunction

  // Monitor: mosi checked before each sampling rise, RX word checked when busy drops
  initial begin
    forever begin
      @(negedge clk);
      if (!rstn) begin
        pb_m = 1'b0;
        pb_l = 1'b0;
      end else begin
        if (in_xfer && spi_clk) begin
          if (mq_m.size() == 0 || mq_l.size() == 0) chk("mosi_queue_underflow", 1, 0);
          else begin
            chk("mosi_msb", m_mosi, mq_m.pop_front());
            chk("mosi_lsb", l_mosi, mq_l.pop_front());
          end
        end
        if (pb_m && !m_busy) begin
          if (rxq_m.size() == 0) chk("rx_msb_unexpected", 1, 0);
          else begin
            e_m = rxq_m.pop_front();
            chk("rx_data_msb", m_rx_data, e_m.data);
            chk("rx_valid_msb", m_rx_valid, 1);
            chk("rx_overrun_msb", m_ovr, e_m.ovr);
          end
        end
        if (pb_l && !l_busy) begin
          if (rxq_l.size() == 0) chk("rx_lsb_unexpected", 1, 0);
          else begin
            e_l = rxq_l.pop_front();
            chk("rx_data_lsb", l_rx_data, e_l.data);
            chk("rx_valid_lsb", l_rx_valid, 1);
            chk("rx_overrun_lsb", l_ovr, e_l.ovr);
          end
        end
        pb_m = m_busy;
        pb_l = l_busy;
      end
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic push_tx(input logic [7:0] d);
    chk("tx_ready_before_push", m_tx_ready, !mdl_hold_full);
    tx_data = d; tx_valid = 1'b1;
    step;
    tx_valid = 1'b0;
    mdl_hold = d; mdl_hold_full = 1'b1;
    chk("tx_ready_after_push_msb", m_tx_ready, 0);
    chk("tx_ready_after_push_lsb", l_tx_ready, 0);
  endtask

  task automatic try_push_full(input logic [7:0] d);
    tx_data = d; tx_valid = 1'b1;
    step;
    tx_valid = 1'b0;
    chk("tx_ready_stays_full", m_tx_ready, 0);
  endtask

  // mode 0: from hold register, 1: bypass with tx_valid, 2: dummy (no data)
  task automatic start(input int mode, input logic [7:0] d);
    logic [7:0] w;
    w = (mode == 0) ? mdl_hold : (mode == 1) ? d : 8'hFF;
    load = 1'b1;
    if (mode == 1) begin tx_valid = 1'b1; tx_data = d; end
    step;
    load = 1'b0; tx_valid = 1'b0;
    mdl_hold_full = 1'b0;
    chk("busy_after_load_msb", m_busy, 1);
    chk("busy_after_load_lsb", l_busy, 1);
    chk("tx_ready_after_load", m_tx_ready, 1);
    mq_m.delete(); mq_l.delete();
    for (int i = 0; i < 8; i++) begin
      mq_m.push_back(w[7-i]);
      mq_l.push_back(w[i]);
    end
    in_xfer = 1'b1;
  endtask

  task automatic shift_bits(input logic [7:0] rxw, input int n, input bit comb, input bit ack_last);
    rx_exp_t em, el;
    for (int i = 0; i < n; i++) begin
      miso = rxw[7-i]; spi_clk = 1'b1; shift_en = comb;
      if (i == 7) begin
        em.data = rxw;        em.ovr = mdl_pending && !ack_last;
        el.data = rev8(rxw);  el.ovr = em.ovr;
        rxq_m.push_back(em); rxq_l.push_back(el);
        mdl_pending = 1'b1;
        rx_ack = ack_last;
      end
      step;
      if (i == 7) in_xfer = 1'b0;
      spi_clk = 1'b0; shift_en = !comb; rx_ack = 1'b0;
      step;
      shift_en = 1'b0;
    end
    if (n == 8) begin
      chk("idle_busy", m_busy, 0);
      chk("idle_mosi_msb", m_mosi, 1);
      chk("idle_mosi_lsb", l_mosi, 1);
    end
  endtask

  task automatic do_ack;
    rx_ack = 1'b1;
    step;
    rx_ack = 1'b0;
    mdl_pending = 1'b0;
    chk("ack_valid_msb", m_rx_valid, 0);
    chk("ack_valid_lsb", l_rx_valid, 0);
    chk("ack_overrun_msb", m_ovr, 0);
  endtask

  task automatic xfer(input int mode, input logic [7:0] txw, input logic [7:0] rxw, input bit comb, input int ackp);
    if (mode == 0) push_tx(txw);
    start(mode, txw);
    shift_bits(rxw, 8, comb, ackp == 2);
    if (ackp == 1) do_ack();
  endtask

  task automatic reset_mid;
    @(posedge clk);
    #3 rstn = 1'b0;
    #1;
    chk("rst_busy", m_busy, 0);
    chk("rst_mosi_msb", m_mosi, 1);
    chk("rst_mosi_lsb", l_mosi, 1);
    chk("rst_rx_valid", m_rx_valid, 0);
    chk("rst_tx_ready", m_tx_ready, 1);
    chk("rst_overrun", m_ovr, 0);
    mdl_pending = 1'b0; mdl_hold_full = 1'b0;
    mq_m.delete(); mq_l.delete(); in_xfer = 1'b0;
    spi_clk = 1'b0; shift_en = 1'b0; rx_ack = 1'b0; miso = 1'b0; load = 1'b0; tx_valid = 1'b0;
    step; step;
    rstn = 1'b1;
    step;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0; tx_valid = 1'b0; tx_data = 8'h00; load = 1'b0;
    shift_en = 1'b0; spi_clk = 1'b0; miso = 1'b0; rx_ack = 1'b0;
    step; step;
    chk("reset_rx_data", m_rx_data, 0);
    chk("reset_rx_valid", m_rx_valid, 0);
    chk("reset_overrun", m_ovr, 0);
    chk("reset_busy", m_busy, 0);
    chk("reset_mosi", m_mosi, 1);
    chk("reset_tx_ready", m_tx_ready, 1);
    rstn = 1'b1;
    step;

    push_tx(8'h0F);
    try_push_full(8'hEE);
    start(0, 8'h00);
    shift_bits(8'hA5, 8, 1'b0, 1'b0);
    do_ack();

    start(1, 8'h3C);
    shift_bits(8'h96, 8, 1'b1, 1'b0);
    do_ack();

    start(2, 8'h00);
    shift_bits(8'h5A, 8, 1'b0, 1'b0);
    do_ack();

    xfer(1, 8'h11, 8'h11, 1'b0, 0);
    xfer(1, 8'h22, 8'h22, 1'b0, 0);
    do_ack();
    xfer(1, 8'h33, 8'h33, 1'b0, 0);
    xfer(1, 8'h44, 8'h44, 1'b1, 2);
    do_ack();

    start(1, 8'h99);
    shift_bits(8'h99, 3, 1'b0, 1'b0);
    reset_mid();
    xfer(0, 8'hC3, 8'hC3, 1'b0, 1);

    xfer(1, 8'h01, 8'h01, 1'b0, 1);
    start(1, 8'h42);
    shift_bits(8'hF0, 3, 1'b0, 1'b0);
    start(1, 8'hFF);
    shift_bits(8'h6D, 8, 1'b1, 1'b0);
    do_ack();

    for (int k = 0; k < 20; k++) begin
      if ($urandom_range(0, 4) == 0) begin
        start(1, 8'($urandom));
        shift_bits(8'($urandom), int'($urandom_range(1, 6)), 1'($urandom), 1'b0);
      end
      xfer(int'($urandom_range(0, 2)), 8'($urandom), 8'($urandom), 1'($urandom), int'($urandom_range(0, 2)));
    end

    step; step; step;
    chk("rx_queue_msb_drained", rxq_m.size(), 0);
    chk("rx_queue_lsb_drained", rxq_l.size(), 0);
    chk("mosi_queue_drained", mq_m.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_master_datapath.md
Name: spi_master_datapath

Overview:
Byte datapath paired with SPIMasterControl in the AHB SPI master. Buffers one transmit word from the bus-side logic and shifts it out on MOSI under the controller's load_data_en/shift_enable strobes. Samples MISO on rising spi_clk edges and presents each received word with a valid/ack handshake.
SPI mode 0 only: MOSI is valid before the first rising edge, MISO is sampled on rising edges, and MOSI shifts on falling edges, signalled by shift_enable.

Parameters:
DATA_WIDTH, 8, bits per transfer (≥2)
MSB_FIRST, 1, 1 = MSB shifted/received first; 0 = LSB first

Ports:
clk_i  in  1  system clock (HCLK)
rstn_i  in  1  reset; asynchronous, active-low
tx_data_i  in  DATA_WIDTH  word to transmit
tx_valid_i  in  1  tx_data_i valid
tx_ready_o  out  1  TX holding register empty
load_data_en_i  in  1  1-cycle strobe from SPIMasterControl: start transfer
shift_enable_i  in  1  1-cycle strobe from SPIMasterControl: advance MOSI one bit
spi_clk_i  in  1  spi_clk_o of SPIMasterControl (synchronous to clk_i)
miso_i  in  1  serial input
mosi_o  out  1  serial output
rx_data_o  out  DATA_WIDTH  last received word
rx_valid_o  out  1  rx_data_o holds an unacknowledged word
rx_ack_i  in  1  consumer accepts rx_data_o
rx_overrun_o  out  1  sticky: a word was overwritten before it was acknowledged
busy_o  out  1  transfer in progress

Behaviour:
- Reset (async, rstn_i=0):
  - hold_full=0, shift_reg=all ones, rx_shift=0, bit_cnt=0, spi_clk_q=0.
  - Outputs: rx_data_o=0, rx_valid_o=0, rx_overrun_o=0, busy_o=0, mosi_o=1, tx_ready_o=1.
- tx_ready_o = ~hold_full (combinational). A tx_valid_i & tx_ready_o cycle captures tx_data_i into the hold register and sets hold_full. tx_valid_i while full is ignored; the upstream must hold it.
- Load (load_data_en_i=1):
  - hold_full=1: shift_reg<=hold, hold_full<=0.
  - hold_full=0 and tx_valid_i=1 in the same cycle: bypass. shift_reg<=tx_data_i; the hold register stays empty.
  - hold_full=0 and tx_valid_i=0: dummy read. shift_reg<=all ones.
  - In all cases: bit_cnt<=0, rx_shift<=0, busy_o<=1.
  - Load while busy_o=1 aborts the current transfer. The partial RX word is discarded and the restart is identical to a load from idle.
- mosi_o:
  - busy_o=1: shift_reg[DATA_WIDTH-1] if MSB_FIRST, else shift_reg[0].
  - busy_o=0: 1.
- Shift: shift_enable_i & busy_o shifts shift_reg one place toward the output bit and fills the vacated bit with 1. The strobe is ignored when idle.
- Sample:
  - rise = spi_clk_i & ~spi_clk_q, with spi_clk_q registered every cycle.
  - On rise & busy_o: capture miso_i into rx_shift. MSB_FIRST shifts left with the new bit in the LSB; otherwise it shifts right with the new bit in the MSB. Then bit_cnt++.
  - rise while idle is ignored.
- Completion is the rise that makes bit_cnt reach DATA_WIDTH. On the next clk edge:
  - rx_data_o <= full word, including the bit just sampled.
  - rx_valid_o<=1, busy_o<=0, bit_cnt<=0.
  - Latency: rx_valid_o is high 1 clk after the cycle in which the last rising spi_clk is seen.
- Overrun: completion while rx_valid_o=1 and rx_ack_i=0 overwrites rx_data_o and sets rx_overrun_o.
- rx_ack_i:
  - rx_ack_i & rx_valid_o with no completion: rx_valid_o<=0 and rx_overrun_o<=0 on the next edge.
  - rx_ack_i coincident with completion: new word latched, rx_valid_o stays 1, no overrun flagged.
  - rx_ack_i while rx_valid_o=0: no effect.
- Simultaneous load and completion: the completion is registered (rx_data_o/rx_valid_o update) and the new transfer starts (busy_o stays 1).
- shift_enable_i and rise in the same cycle are both applied: the sample uses miso_i and the shift uses the current shift_reg.
- Reset mid-transfer: everything returns immediately to reset values; no partial word is reported.

Test Plan:
1. Reset, then push tx 8'h0F. Expect tx_ready_o 1→0. Load, then 8 controller shift/rise pairs with miso_i driving 8'hA5 MSB-first. Expect mosi_o sequence 0,0,0,0,1,1,1,1; rx_data_o=8'hA5 with rx_valid_o=1 one clk after the 8th rise; busy_o=0; mosi_o=1.
2. Hold register empty; tx_valid_i=1 with data 8'h3C coincident with load_data_en_i. Expect bypass: mosi bits 0,0,1,1,1,1,0,0, tx_ready_o stays 1.
3. Load with hold empty and no tx_valid_i. Expect mosi_o=1 for all 8 bits; the received word 8'h5A is still reported.
4. Complete 8'h11 without ack, then complete 8'h22. Expect rx_data_o=8'h22, rx_overrun_o=1. Assert rx_ack_i. Expect rx_valid_o=0, rx_overrun_o=0. Repeat with rx_ack_i coincident with completion: rx_valid_o stays 1, rx_overrun_o=0.
5. Pull rstn_i low after 3 bits, asynchronously between clk edges. Expect immediate busy_o=0, mosi_o=1, rx_valid_o=0, tx_ready_o=1. A subsequent full transfer of 8'hC3 works.
6. MSB_FIRST=0, tx 8'h01, miso_i driving 8'h80 LSB-first. Expect mosi_o first bit 1 then 0s; rx_data_o=8'h80. Mid-transfer reload with 8'hFF aborts; the next completion reports only the new word.
